// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [1:0] RSN_NONE      = 2'b00;
  localparam logic [1:0] RSN_LOAD_USE  = 2'b01;
  localparam logic [1:0] RSN_BRANCH_OP = 2'b10;
  localparam logic [1:0] RSN_MULDIV    = 2'b11;

  function automatic logic [1:0] pick_reason(input logic load_use, input logic branch_op,
                                             input logic muldiv);
    if (load_use)       return RSN_LOAD_USE;
    else if (branch_op) return RSN_BRANCH_OP;
    else if (muldiv)    return RSN_MULDIV;
    else                return RSN_NONE;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Does a pipeline destination register feed an operand of the ID-stage instruction?
module hazard_match
  import hazard_pkg::*;
(
  input  logic [4:0] rd_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       uses_rt_i,
  output logic       match_o
);

  // $zero is never a real dependency, even if a stage names it as destination
  assign match_o = (rd_i != REG_ZERO) && ((rd_i == rs_i) || (uses_rt_i && (rd_i == rt_i)));

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use / branch-operand stalls, branch/jump flush, mult/div sequencing.
// Build option HAZARD_MULDIV_EN enables the mult/div start/done FSM and reason 11 stalls.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             branch_taken,
  input  logic             id_muldiv,
  input  logic             id_mfhilo,
  input  logic             idex_memread,
  input  logic             idex_regwrite,
  input  logic [4:0]       idex_rd,
  input  logic             exmem_memread,
  input  logic [4:0]       exmem_rd,
  input  logic             md_done,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             md_start,
  output logic [1:0]       stall_reason,
  output logic [CNT_W-1:0] stall_count
);

  logic match_ex;
  logic match_mem;
  logic load_use;
  logic branch_op;
  logic md_stall;
  logic md_go;
  logic stall;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  hazard_match u_match_ex (
    .rd_i      (idex_rd),
    .rs_i      (id_rs),
    .rt_i      (id_rt),
    .uses_rt_i (id_uses_rt),
    .match_o   (match_ex)
  );

  hazard_match u_match_mem (
    .rd_i      (exmem_rd),
    .rs_i      (id_rs),
    .rt_i      (id_rt),
    .uses_rt_i (id_uses_rt),
    .match_o   (match_mem)
  );

  assign load_use  = idex_memread && match_ex;
  // ID-stage compare needs the value now, so even an ALU result still in EX must wait
  assign branch_op = id_branch && ((idex_regwrite && match_ex) || (exmem_memread && match_mem));

`ifdef HAZARD_MULDIV_EN
  md_state_e state_q, state_d;

  assign md_stall = (state_q == MD_BUSY) && (id_muldiv || id_mfhilo) && !md_done;
  // A new op may launch from IDLE, or back-to-back in the cycle the previous one completes
  assign md_go    = id_muldiv && !(load_use || branch_op || md_stall)
                    && ((state_q == MD_IDLE) || md_done);

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (md_go) state_d = MD_BUSY;
      MD_BUSY: if (md_done && !md_go) state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MD_IDLE;
    else     state_q <= state_d;
  end
`else
  logic unused_md;

  assign unused_md = ^{md_done, id_muldiv, id_mfhilo};
  assign md_stall  = 1'b0;
  assign md_go     = 1'b0;
`endif

  assign stall = load_use || branch_op || md_stall;

  always_comb begin
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b1;
    md_start     = 1'b0;
    stall_reason = RSN_NONE;
    if (!rst) begin
      stall_reason = pick_reason(load_use, branch_op, md_stall);
      if (!stall) begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = id_jump || (id_branch && branch_taken);
        md_start    = md_go;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != {CNT_W{1'b1}})) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_count_q <= '0;
    else     stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus randomized bench for hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;

`ifdef HAZARD_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, idex_rd, exmem_rd;
  logic id_uses_rt, id_branch, id_jump, branch_taken, id_muldiv, id_mfhilo;
  logic idex_memread, idex_regwrite, exmem_memread, md_done;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, md_start;
  logic [1:0] stall_reason;
  logic [15:0] stall_count;
  logic pc_write2, ifid_write2, ifid_flush2, idex_bubble2, md_start2;
  logic [1:0] stall_reason2;
  logic [1:0] stall_count2;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_busy = 0;
  int m_cnt = 0;
  int m_cnt2 = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .id_jump(id_jump), .branch_taken(branch_taken),
    .id_muldiv(id_muldiv), .id_mfhilo(id_mfhilo), .idex_memread(idex_memread),
    .idex_regwrite(idex_regwrite), .idex_rd(idex_rd), .exmem_memread(exmem_memread),
    .exmem_rd(exmem_rd), .md_done(md_done), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .md_start(md_start),
    .stall_reason(stall_reason), .stall_count(stall_count)
  );

  hazard_ctrl #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .id_jump(id_jump), .branch_taken(branch_taken),
    .id_muldiv(id_muldiv), .id_mfhilo(id_mfhilo), .idex_memread(idex_memread),
    .idex_regwrite(idex_regwrite), .idex_rd(idex_rd), .exmem_memread(exmem_memread),
    .exmem_rd(exmem_rd), .md_done(md_done), .pc_write(pc_write2), .ifid_write(ifid_write2),
    .ifid_flush(ifid_flush2), .idex_bubble(idex_bubble2), .md_start(md_start2),
    .stall_reason(stall_reason2), .stall_count(stall_count2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit dep(input logic [4:0] r);
    return (r != 0) && ((r == id_rs) || (id_uses_rt && (r == id_rt)));
  endfunction

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; id_branch = 0; id_jump = 0; branch_taken = 0;
    id_muldiv = 0; id_mfhilo = 0; idex_memread = 0; idex_regwrite = 0; idex_rd = 0;
    exmem_memread = 0; exmem_rd = 0; md_done = 0;
  endtask

  // called just after a falling edge with inputs applied; checks, then advances one clock
  task automatic step(input string tag);
    bit lu, br, md, stall, start, nbusy;
    int reason, ncnt, ncnt2;
    #2;
    if (rst) begin
      chk({tag, ".pc_write"}, pc_write, 0);
      chk({tag, ".ifid_write"}, ifid_write, 0);
      chk({tag, ".ifid_flush"}, ifid_flush, 0);
      chk({tag, ".idex_bubble"}, idex_bubble, 1);
      chk({tag, ".md_start"}, md_start, 0);
      chk({tag, ".reason"}, stall_reason, 0);
      chk({tag, ".count"}, stall_count, 0);
      chk({tag, ".count2"}, stall_count2, 0);
      nbusy = 0; ncnt = 0; ncnt2 = 0;
    end else begin
      lu = idex_memread && dep(idex_rd);
      br = id_branch && ((idex_regwrite && dep(idex_rd)) || (exmem_memread && dep(exmem_rd)));
      md = MD_EN && m_busy && (id_muldiv || id_mfhilo) && !md_done;
      stall = lu || br || md;
      reason = lu ? 1 : (br ? 2 : (md ? 3 : 0));
      start = MD_EN && !stall && id_muldiv && (!m_busy || md_done);
      nbusy = start ? 1'b1 : (md_done ? 1'b0 : m_busy);
      chk({tag, ".pc_write"}, pc_write, !stall);
      chk({tag, ".ifid_write"}, ifid_write, !stall);
      chk({tag, ".idex_bubble"}, idex_bubble, stall);
      chk({tag, ".ifid_flush"}, ifid_flush, !stall && (id_jump || (id_branch && branch_taken)));
      chk({tag, ".md_start"}, md_start, start);
      chk({tag, ".reason"}, stall_reason, reason);
      chk({tag, ".count"}, stall_count, m_cnt);
      chk({tag, ".count2"}, stall_count2, m_cnt2);
      chk({tag, ".small_reason"}, stall_reason2, reason);
      ncnt = stall ? ((m_cnt < 65535) ? m_cnt + 1 : m_cnt) : m_cnt;
      ncnt2 = stall ? ((m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2) : m_cnt2;
    end
    @(posedge clk);
    m_busy = nbusy; m_cnt = ncnt; m_cnt2 = ncnt2;
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    @(negedge clk);
    id_jump = 1; idex_memread = 1; idex_rd = 3; id_rs = 3;
    step("reset_forced");
    clear_inputs();
    rst = 0;
    step("idle");

    // LW $2 in EX, ADD $3,$2,$4 in ID
    idex_memread = 1; idex_regwrite = 1; idex_rd = 2; id_rs = 2; id_rt = 4; id_uses_rt = 1;
    step("load_use");
    clear_inputs();
    step("load_use_after");
    chk("load_use_count", stall_count, 1);

    // ADD $5 in EX, BEQ $5,$6 in ID, then taken branch
    idex_regwrite = 1; idex_rd = 5; id_branch = 1; id_rs = 5; id_rt = 6; id_uses_rt = 1;
    step("branch_op");
    idex_regwrite = 0; idex_rd = 0; exmem_rd = 5; branch_taken = 1;
    step("branch_taken_flush");

    // LW $7 in EX feeding BEQ $7,$0: two stall cycles
    clear_inputs();
    idex_memread = 1; idex_regwrite = 1; idex_rd = 7; id_branch = 1; id_rs = 7; id_uses_rt = 1;
    step("lw_branch_1");
    idex_memread = 0; idex_regwrite = 0; idex_rd = 0; exmem_memread = 1; exmem_rd = 7;
    step("lw_branch_2");
    exmem_memread = 0; exmem_rd = 0;
    step("lw_branch_issue");

    // MULT then MFLO waits for done
    clear_inputs();
    id_muldiv = 1;
    step("mult_issue");
    id_muldiv = 0; id_mfhilo = 1;
    repeat (3) step("mflo_wait");
    md_done = 1;
    step("mflo_release");
    clear_inputs();
    step("after_md");

    // jump with a load to $zero in EX
    id_jump = 1; idex_memread = 1; idex_rd = 0;
    step("jump_flush");
    clear_inputs();

    // reset while busy, then a stray done in IDLE
    id_muldiv = 1;
    step("mult2_issue");
    id_muldiv = 0; id_mfhilo = 1;
    step("mult2_wait");
    rst = 1;
    step("reset_mid_busy");
    rst = 0;
    md_done = 1;
    step("done_in_idle");
    clear_inputs();

    // saturate the narrow counter
    idex_memread = 1; idex_rd = 9; id_rs = 9;
    repeat (5) step("saturate");
    chk("small_count_sat", stall_count2, 3);
    clear_inputs();

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom_range(0, 1));
      id_branch = ($urandom_range(0, 3) == 0);
      id_jump = ($urandom_range(0, 7) == 0);
      branch_taken = 1'($urandom_range(0, 1));
      id_muldiv = ($urandom_range(0, 4) == 0);
      id_mfhilo = ($urandom_range(0, 3) == 0);
      idex_memread = ($urandom_range(0, 3) == 0);
      idex_regwrite = 1'($urandom_range(0, 1));
      idex_rd = 5'($urandom_range(0, 3));
      exmem_memread = ($urandom_range(0, 3) == 0);
      exmem_rd = 5'($urandom_range(0, 3));
      md_done = ($urandom_range(0, 3) == 0);
      step("rand");
    end
    rst = 0;
    clear_inputs();
    step("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
